// File: rtl/spdif_transmit_if.sv
`default_nettype none
// ============================================================================
// Module      : spdif_transmit_if
// Description : Sample input / S/PDIF line output bundle for spdif_transmit.
// Revision    : 1.0 - initial release
// ============================================================================
interface spdif_transmit_if;
    logic [31:0] data_left;
    logic [31:0] data_right;
    logic        spdif_out;
    logic        frame_start;
    logic        block_start;

    modport master (
        output data_left,
        output data_right,
        input  spdif_out,
        input  frame_start,
        input  block_start
    );

    modport slave (
        input  data_left,
        input  data_right,
        output spdif_out,
        output frame_start,
        output block_start
    );
endinterface
`default_nettype wire

// File: rtl/spdif_transmit.sv
`default_nettype none
// ============================================================================
// Module      : spdif_transmit
// Description : IEC 60958 consumer transmitter, one clock per biphase half-cell.
// Revision    : 1.0 - initial release
// ============================================================================
module spdif_transmit #(
    parameter logic [31:0] CS_WORD = 32'h02000004
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    spdif_transmit_if.slave   bus
);

    localparam logic [7:0] c_pre_b = 8'b11101000;
    localparam logic [7:0] c_pre_m = 8'b11100010;
    localparam logic [7:0] c_pre_w = 8'b11100100;

    // r_hc / r_frame index the half-cell that the next edge will drive
    logic [6:0]  r_hc;
    logic [7:0]  r_frame;
    logic [23:0] r_left;
    logic [23:0] r_right;
    logic        r_par;
    logic        r_line;
    logic        r_pre_inv;
    logic        r_fs;
    logic        r_bs;

    logic [4:0]  w_t;
    logic        w_half;
    logic        w_right;
    logic [23:0] w_sample;
    logic [4:0]  w_aidx;
    logic [2:0]  w_pidx;
    logic [7:0]  w_pre;
    logic        w_cs;
    logic        w_bit;
    logic        w_next;
    logic        w_unused;

    assign w_unused = ^{bus.data_left[7:0], bus.data_right[7:0]};

    always_comb begin
        w_t      = r_hc[5:1];
        w_half   = r_hc[0];
        w_right  = r_hc[6];
        w_sample = w_right ? r_right : r_left;
        w_aidx   = w_t - 5'd4;
        w_pidx   = r_hc[2:0];
        w_cs     = (r_frame < 8'd32) ? CS_WORD[r_frame[4:0]] : 1'b0;

        if (w_right)
            w_pre = c_pre_w;
        else if (r_frame == 8'd0)
            w_pre = c_pre_b;
        else
            w_pre = c_pre_m;

        w_bit = 1'b0;
        if (w_t >= 5'd4 && w_t <= 5'd27)
            w_bit = w_sample[w_aidx];
        else if (w_t == 5'd30)
            w_bit = w_cs;
        else if (w_t == 5'd31)
            w_bit = r_par;

        // Preamble polarity follows the line level held just before its first half-cell
        if (w_t < 5'd4)
            w_next = w_pre[3'd7 - w_pidx] ^ ((w_pidx == 3'd0) ? r_line : r_pre_inv);
        else if (!w_half)
            w_next = ~r_line;
        else
            w_next = r_line ^ w_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hc      <= 7'd0;
            r_frame   <= 8'd0;
            r_left    <= 24'd0;
            r_right   <= 24'd0;
            r_par     <= 1'b0;
            r_line    <= 1'b0;
            r_pre_inv <= 1'b0;
            r_fs      <= 1'b0;
            r_bs      <= 1'b0;
        end else begin
            r_line <= w_next;
            r_fs   <= (r_hc == 7'd0);
            r_bs   <= (r_hc == 7'd0) && (r_frame == 8'd0);
            r_hc   <= r_hc + 7'd1;

            if (r_hc == 7'd127)
                r_frame <= (r_frame == 8'd191) ? 8'd0 : r_frame + 8'd1;

            if (r_hc == 7'd0) begin
                r_left  <= bus.data_left[31:8];
                r_right <= bus.data_right[31:8];
            end

            if (w_t < 5'd4 && w_pidx == 3'd0)
                r_pre_inv <= r_line;

            // Parity accumulates each data slot once, on its first half-cell
            if (!w_half) begin
                if (w_t == 5'd0)
                    r_par <= 1'b0;
                else if (w_t >= 5'd4 && w_t <= 5'd30)
                    r_par <= r_par ^ w_bit;
            end
        end
    end

    assign bus.spdif_out   = r_line;
    assign bus.frame_start = r_fs;
    assign bus.block_start = r_bs;

endmodule
`default_nettype wire

// File: tb/tb_spdif_transmit.sv
`default_nettype none
// ============================================================================
// Module      : tb_spdif_transmit
// Description : Scoreboard bench; line is decoded per frame and compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spdif_transmit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spdif_transmit_if bus();

    spdif_transmit #(.CS_WORD(32'h02000004)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [7:0] c_pre_b = 8'b11101000;
    localparam logic [7:0] c_pre_m = 8'b11100010;
    localparam logic [7:0] c_pre_w = 8'b11100100;

    typedef struct {
        logic [7:0]  pre_l;
        logic [7:0]  pre_r;
        logic [23:0] aud_l;
        logic [23:0] aud_r;
        logic        c;
        logic        blk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   fr_idx = 0;

    logic [127:0] lb;
    int           mon_idx;
    bit           mon_coll;
    bit           mon_stray;
    logic         mon_blk0;
    int           mon_cyc;
    int           mon_last_blk;
    bit           mon_have_blk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic push_exp(input logic [31:0] dl, input logic [31:0] dr);
        exp_t e;
        int   f;
        f       = fr_idx % 192;
        e.pre_l = (f == 0) ? c_pre_b : c_pre_m;
        e.pre_r = c_pre_w;
        e.aud_l = dl[31:8];
        e.aud_r = dr[31:8];
        e.c     = (f == 2) || (f == 25);
        e.blk   = (f == 0);
        sb.push_back(e);
        fr_idx++;
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_start && n < 200);
        if (!bus.frame_start) begin
            checks++;
            errors++;
            $display("FAIL frame_start_timeout: got no frame_start in %0d cycles, expected one within 128", n);
            finish_run();
        end
    endtask

    task automatic run_frame(input logic [31:0] dl, input logic [31:0] dr);
        bus.data_left  = dl;
        bus.data_right = dr;
        push_exp(dl, dr);
        wait_fs();
    endtask

    // Biphase-mark decode of one 64-half-cell subframe starting at base
    task automatic decode_sub(input logic [127:0] l, input int base,
                              output logic [7:0] pre, output logic [23:0] aud,
                              output logic [2:0] vuc, output logic p,
                              output logic ok, output logic endl);
        logic prev, h0, h1;
        logic [31:0] sf;
        for (int k = 0; k < 8; k++) pre[7-k] = l[base+k];
        prev = l[base+7];
        ok   = 1'b1;
        sf   = '0;
        for (int t = 4; t < 32; t++) begin
            h0 = l[base+2*t];
            h1 = l[base+2*t+1];
            if (h0 == prev) ok = 1'b0;
            sf[t] = h0 ^ h1;
            prev  = h1;
        end
        aud  = sf[27:4];
        vuc  = sf[30:28];
        p    = sf[31];
        endl = l[base+63];
    endtask

    task automatic score_frame(input logic [127:0] l, input logic blk, input bit stray);
        exp_t        e;
        logic [7:0]  pre;
        logic [23:0] aud;
        logic [2:0]  vuc;
        logic        p, ok, endl;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got a frame, expected none");
            return;
        end
        e = sb.pop_front();
        check("block_start", blk, e.blk);
        check("stray_strobe", stray, 0);

        decode_sub(l, 0, pre, aud, vuc, p, ok, endl);
        check("pre_left", pre, e.pre_l);
        check("audio_left", aud, e.aud_l);
        check("vuc_left", vuc, {e.c, 2'b00});
        check("parity_left", p, (^e.aud_l) ^ e.c);
        check("bmc_left", ok, 1);
        check("level_hc63", endl, 0);

        decode_sub(l, 64, pre, aud, vuc, p, ok, endl);
        check("pre_right", pre, e.pre_r);
        check("audio_right", aud, e.aud_r);
        check("vuc_right", vuc, {e.c, 2'b00});
        check("parity_right", p, (^e.aud_r) ^ e.c);
        check("bmc_right", ok, 1);
        check("level_hc127", endl, 0);
    endtask

    initial begin
        mon_idx = 0; mon_coll = 0; mon_stray = 0; mon_blk0 = 0;
        mon_cyc = 0; mon_last_blk = 0; mon_have_blk = 0; lb = '0;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (!rst_n) begin
                mon_coll     = 0;
                mon_have_blk = 0;
            end else begin
                if (bus.block_start) begin
                    if (mon_have_blk) check("block_period", mon_cyc - mon_last_blk, 24576);
                    mon_last_blk = mon_cyc;
                    mon_have_blk = 1;
                end
                if (bus.frame_start) begin
                    mon_coll  = 1;
                    mon_idx   = 0;
                    mon_stray = 0;
                    mon_blk0  = bus.block_start;
                end else if (mon_coll && bus.block_start) begin
                    mon_stray = 1;
                end
                if (mon_coll) begin
                    lb[mon_idx] = bus.spdif_out;
                    mon_idx++;
                    if (mon_idx == 128) begin
                        mon_coll = 0;
                        score_frame(lb, mon_blk0, mon_stray);
                    end
                end
            end
        end
    end

    initial begin
        bus.data_left  = '0;
        bus.data_right = '0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.data_left  = $urandom;
            bus.data_right = $urandom;
            @(posedge clk);
            #1;
            check("reset_outputs", {bus.spdif_out, bus.frame_start, bus.block_start}, 3'b000);
        end

        @(negedge clk);
        bus.data_left  = 32'h00000100;
        bus.data_right = 32'h00000000;
        push_exp(32'h00000100, 32'h00000000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_cycle", {bus.spdif_out, bus.frame_start, bus.block_start}, 3'b111);
        @(negedge clk);

        run_frame(32'hFFFFFF00, 32'h00000000);
        repeat (10) @(negedge clk);
        bus.data_left = 32'h00000000;
        run_frame(32'h00000000, 32'h00000000);
        run_frame(32'h12345678, 32'h87654321);
        run_frame(32'h80000000, 32'h000000FF);
        for (int i = 5; i < 197; i++)
            run_frame((32'(i) * 32'h01030700) ^ 32'hA5000000, ~(32'(i) * 32'h00110100));
        run_frame(32'h00000000, 32'h00000000);

        repeat (40) @(negedge clk);
        check("level_before_reset", bus.spdif_out, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset", {bus.spdif_out, bus.frame_start, bus.block_start}, 3'b000);
        sb.delete();
        fr_idx = 0;
        repeat (3) @(negedge clk);
        check("reset_hold", {bus.spdif_out, bus.frame_start, bus.block_start}, 3'b000);

        bus.data_left  = 32'h00ABCD00;
        bus.data_right = 32'hFEDCBA00;
        push_exp(32'h00ABCD00, 32'hFEDCBA00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_cycle", {bus.spdif_out, bus.frame_start, bus.block_start}, 3'b111);
        @(negedge clk);
        run_frame(32'h5A5A5A00, 32'h0F0F0F00);
        run_frame(32'hC3C3C300, 32'h3C3C3C00);

        repeat (130) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        finish_run();
    end

endmodule
`default_nettype wire

// File: doc/spdif_transmit.md
# spdif_transmit

S/PDIF (IEC 60958 consumer) transmitter stage that sits directly downstream of the I2S receiver. It captures the parallel left/right 32-bit words once per frame, packs the upper 24 bits into two subframes with V/U/C/P bits and B/M/W preambles, and drives a biphase-mark-coded line. It is clocked at 128 × fs, one clock per biphase half-cell.

## Interface
Parameters:
- CS_WORD, 32'h02000004, channel-status bits 0..31 (bit n sent in frame n); bit 2 = copy permitted, bits 27:24 = 4'b0010 (48 kHz); frames 32..191 send C = 0.

Ports:
- clk  in  1  half-cell clock, 128 × fs, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_left  in  32  left sample, MSB-justified; bits 31:8 are transmitted.
- data_right  in  32  right sample, same format.
- spdif_out  out  1  biphase-mark line output, registered.
- frame_start  out  1  high for one cycle while half-cell 0 of any frame is driven.
- block_start  out  1  high for one cycle while half-cell 0 of frame 0 is driven.

## Operation
- State:
  - hc: 7-bit half-cell counter, 0..127, wraps.
  - frame: 8-bit frame counter, 0..191; increments when hc wraps 127→0, and 191 wraps to 0.
  - Slot s = hc[6:1]. Left subframe is s = 0..31; right subframe is s = 32..63 (local slot t = s mod 32).
- Capture: on the edge that drives hc = 0, register data_left[31:8] and data_right[31:8] into holding registers. These stay unchanged for the whole frame.
- Subframe slots:
  - t 0–3: preamble.
  - t 4–27: audio bits 0..23, LSB first (holding bit 8 first, bit 31 last).
  - t 28: V = 0.
  - t 29: U = 0.
  - t 30: C = CS_WORD[frame] if frame < 32, else 0.
  - t 31: P, even parity over t 4..30 of the same subframe.
  - Parity uses a running XOR that clears at t = 0.
- Preamble, 8 half-cells, first to last, referenced to line level 0:
  - B = 11101000 (left, frame 0).
  - M = 11100010 (left, other frames).
  - W = 11100100 (right).
  - If the line level before the preamble is 1, the pattern is inverted.
  - Preambles are not biphase-coded.
- Biphase mark, t 4..31: the line toggles at the first half-cell of each slot. It toggles again at the second half-cell only if the bit is 1.
- Even parity means the line level at every subframe boundary equals the level at reset (0).
- Reset (async, rst_n = 0):
  - Outputs: spdif_out = 0, frame_start = 0, block_start = 0.
  - State: hc = 0, frame = 0, holding registers = 0, parity = 0.
  - Mid-frame reset aborts the frame immediately. No partial frame is completed.

## Timing
- The first rising edge after rst_n deasserts drives hc = 0 of frame 0: B preamble, frame_start = block_start = 1.
- Every subsequent edge advances one half-cell.
- Frame period is 128 cycles; block period is 24576 cycles.
- Latency: a sample present at the capture edge has its LSB on the line at hc 8–9 (left) or hc 72–73 (right). Its parity appears at hc 62–63 / 126–127.
- Input changes at any edge other than hc = 0 have no effect on the current frame.
- frame_start and block_start are registered together with spdif_out, aligned to the half-cell they flag.

## Test plan
- Reset: hold rst_n low, toggle inputs → spdif_out = 0 and both strobes 0. Release → first cycle: spdif_out = 1, frame_start = 1, block_start = 1; the first 8 half-cells read 11101000.
- Data and parity:
  - data_left = 32'h00000100 (audio LSB = 1), data_right = 0 → left t4 encodes 1 (two toggles); left P = 1; right P = 0.
  - Decoded left audio = 24'h000001, right = 24'h000000.
  - Line level is 0 at hc 0 and hc 64.
- Preamble sequencing: frame 0 left B, frames 1..191 left M, all right subframes W. Frame 192 is B again; block_start is spaced by 24576 cycles.
- Channel status: default CS_WORD → C = 1 in frames 2 and 25 only, within frames 0..31; frames 32..191 give C = 0, both subframes.
- Capture window:
  - data_left = 32'hFFFFFF00 at hc 0, changed to 0 at hc 10 → whole frame decodes 24'hFFFFFF.
  - Next frame decodes 0.
- Mid-frame reset: assert rst_n at hc 40 of frame 5 → spdif_out drops to 0 asynchronously. After release, the next frame starts with B and block_start = 1.
